iterative_right_shifter: RTL and testbench

Multi-cycle 32-bit right shifter for the processor's execute stage. It handles SRL/SRA one bit position per cycle, so the datapath needs no combinational barrel shifter. A start/ready/done handshake lets the stall logic hold the pipeline while a shift is in flight. It is the right-direction counterpart of the fixed left-shift used for word/branch offset scaling.

---
 rtl/iterative_right_shifter_pkg.sv | 17 +
 rtl/iterative_right_shifter_shift_step_unit.sv | 31 +++
 rtl/iterative_right_shifter.sv | 120 ++++++++++++
 tb/tb_iterative_right_shifter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/iterative_right_shifter_pkg.sv
// Shared types and constants for the iterative right shifter.
// Optional 4-bit step mode is enabled by defining RSHIFT_STEP4_EN.
package iterative_right_shifter_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic LOGICAL = 1'b0;
    localparam logic ARITH   = 1'b1;

endpackage

// File: rtl/iterative_right_shifter_shift_step_unit.sv
// Combinational single right-shift step of 1 or 4 bit positions with
// sign or zero fill; kept separate so a left-direction twin can reuse the shape.
module iterative_right_shifter_shift_step_unit
    import iterative_right_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic             arith_i,
    input  logic             step4_i,
    output logic [WIDTH-1:0] next_o
);

    logic fill_s;

    // Select the fill bit and apply one step of the requested size.
    always_comb begin
        fill_s = 1'b0;
        if (arith_i == ARITH) begin
            fill_s = work_i[WIDTH-1];
        end else begin
            fill_s = 1'b0;
        end
        if (step4_i) begin
            next_o = {{4{fill_s}}, work_i[WIDTH-1:4]};
        end else begin
            next_o = {fill_s, work_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iterative_right_shifter.sv
// Multi-cycle SRL/SRA unit with start/ready/busy/done handshake.
// Define RSHIFT_STEP4_EN to take 4-bit steps while at least 4 positions remain.
module iterative_right_shifter
    import iterative_right_shifter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   result,
    output logic               ready,
    output logic               busy,
    output logic               done
);

    localparam logic [SHAMT_W-1:0] DEC1 = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] DEC4 = SHAMT_W'(4);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               mode_q, mode_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               step4_s;
    logic [WIDTH-1:0]   step_next_s;

    // Choose the step size for the current shift cycle.
    always_comb begin
`ifdef RSHIFT_STEP4_EN
        if (count_q >= DEC4) begin
            step4_s = 1'b1;
        end else begin
            step4_s = 1'b0;
        end
`else
        step4_s = 1'b0;
`endif
    end

    iterative_right_shifter_shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .work_i  (work_q),
        .arith_i (mode_q),
        .step4_i (step4_s),
        .next_o  (step_next_s)
    );

    // Next-state and datapath update; flags are derived from the next state
    // so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    count_d = shamt;
                    mode_d  = arith;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    work_d  = step_next_s;
                    count_d = count_q - (step4_s ? DEC4 : DEC1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SHIFT) || (state_d == DONE);
        done_d  = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            mode_q  <= LOGICAL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result = work_q;
    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_iterative_right_shifter.sv
// Randomized self-checking bench for iterative_right_shifter against an
// arithmetic reference model; honours RSHIFT_STEP4_EN for latency.
module tb_iterative_right_shifter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] result;
    logic        ready;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    iterative_right_shifter dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .arith   (arith),
        .result  (result),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return sd >>> s;
        return d >> s;
    endfunction

    function automatic int ref_latency(input int s);
`ifdef RSHIFT_STEP4_EN
        return s / 4 + s % 4 + 2;
`else
        return s + 2;
`endif
    endfunction

    // Called #1 after a rising edge with the DUT expected idle.
    task automatic run_op(input logic [31:0] d, input int s, input logic a, input bit scramble);
        logic [31:0] exp_res;
        int          k;
        bit          seen;
        exp_res = ref_shift(d, s, a);
        chk("ready_before", 32'(ready), 32'd1);
        data_in = d;
        shamt   = 5'(s);
        arith   = a;
        start   = 1'b1;
        @(posedge clock); #1;
        k    = 1;
        seen = 1'b0;
        while (!seen && k <= 100) begin
            chk("busy_inflight", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                chk("latency", k, ref_latency(s));
                chk("result", result, exp_res);
                chk("ready_in_done", 32'(ready), 32'd0);
            end
            if (scramble) begin
                data_in = $urandom;
                shamt   = 5'($urandom_range(0, 31));
                arith   = 1'($urandom_range(0, 1));
                start   = seen ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (!seen) begin
                @(posedge clock); #1;
                k++;
            end
        end
        if (!seen) chk("timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        start = 1'b0;
        chk("ready_after", 32'(ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("result_held", result, exp_res);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 32'd0;
        shamt   = 5'd0;
        arith   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(32'h8000_0000, 31, 1'b0, 1'b0);
        run_op(32'h8000_0000, 31, 1'b1, 1'b0);
        run_op(32'h8000_0000, 4, 1'b1, 1'b0);
        run_op(32'h1234_5678, 0, 1'b0, 1'b0);
        run_op(32'h0000_00F0, 4, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 31, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 13, 1'b1, 1'b1);

        // Reset while a 20-position shift is in flight.
        data_in = 32'hABCD_1234;
        shamt   = 5'd20;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            chk("rst_mid_nodone", 32'(done), 32'd0);
            @(posedge clock); #1;
        end
        reset = 1'b1;
        chk("rst_mid_nodone", 32'(done), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_mid_ready", 32'(ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        run_op(32'h0000_0100, 8, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
